dpram_bw: RTL and testbench

Parametrised true dual-port synchronous RAM with per-lane byte write enables, a selectable read-during-write mode, an optional output register stage and a hardware clear sequencer. It is the successor to the two-port register-file RAM used inside the core datapath. It adds a second write port, lane-granular writes, read-valid strobes, and a deterministic power-up and on-demand zero-fill, so no simulation-only initialisation is needed. Both ports share one clock domain.

---
 rtl/dpram_bw.sv | 153 +++++++++++++++
 tb/tb_dpram_bw.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_bw.sv
// True dual-port synchronous RAM with per-lane write enables, selectable
// read-during-write behaviour, optional output register and a zero-fill sequencer.
module dpram_bw #(
    parameter int unsigned   AW    = 5,
    parameter int unsigned   NL    = 4,
    parameter int unsigned   LW    = 8,
    parameter int unsigned   WMODE = 0,
    parameter int unsigned   OREG  = 0,
    parameter logic [LW-1:0] INITV = '0,
    localparam int unsigned  DW    = NL * LW
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          ena_i,
    input  logic          clr_i,
    output logic          bsy_o,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] dat_i,
    input  logic [NL-1:0] wre_i,
    output logic [DW-1:0] dat_o,
    output logic          vld_o,
    input  logic [AW-1:0] xadr_i,
    input  logic [DW-1:0] xdat_i,
    input  logic [NL-1:0] xwre_i,
    output logic [DW-1:0] xdat_o,
    output logic          xvld_o
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        S_CLR,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          acc;
    logic [NL-1:0] wa, wx;
    logic [DW-1:0] rd_a, rd_x;
    logic [DW-1:0] q1_a, q1_x;
    logic          v1_q;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_CLR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_CLR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                if (clr_i) begin
                    state_d = S_CLR;
                    ptr_d   = '0;
                end
            end
            default: state_d = S_CLR;
        endcase
    end

    assign bsy_o = (state_q == S_CLR);
    assign acc   = (state_q == S_RUN) && ena_i;
    assign wa    = acc ? wre_i  : '0;
    assign wx    = acc ? xwre_i : '0;

    // Port A lanes are written after port X so they win on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (state_q == S_CLR) begin
            mem[ptr_q] <= {NL{INITV}};
        end else begin
            for (int unsigned k = 0; k < NL; k++) begin
                if (wx[k]) mem[xadr_i][k*LW +: LW] <= xdat_i[k*LW +: LW];
                if (wa[k]) mem[adr_i][k*LW +: LW]  <= dat_i[k*LW +: LW];
            end
        end
    end

    always_comb begin
        rd_a = mem[adr_i];
        rd_x = mem[xadr_i];
        if (WMODE != 0) begin
            for (int unsigned k = 0; k < NL; k++) begin
                if (wa[k])
                    rd_a[k*LW +: LW] = dat_i[k*LW +: LW];
                else if (wx[k] && (xadr_i == adr_i))
                    rd_a[k*LW +: LW] = xdat_i[k*LW +: LW];
                if (wa[k] && (adr_i == xadr_i))
                    rd_x[k*LW +: LW] = dat_i[k*LW +: LW];
                else if (wx[k])
                    rd_x[k*LW +: LW] = xdat_i[k*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q1_a <= '0;
            q1_x <= '0;
            v1_q <= 1'b0;
        end else begin
            if (acc) begin
                q1_a <= rd_a;
                q1_x <= rd_x;
            end
            v1_q <= acc;
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] q2_a, q2_x;
            logic          v2_q;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    q2_a <= '0;
                    q2_x <= '0;
                    v2_q <= 1'b0;
                end else begin
                    if (v1_q) begin
                        q2_a <= q1_a;
                        q2_x <= q1_x;
                    end
                    v2_q <= v1_q;
                end
            end

            assign dat_o  = q2_a;
            assign xdat_o = q2_x;
            assign vld_o  = v2_q;
            assign xvld_o = v2_q;
        end else begin : g_noreg
            assign dat_o  = q1_a;
            assign xdat_o = q1_x;
            assign vld_o  = v1_q;
            assign xvld_o = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_bw.sv
// Directed bench for dpram_bw: three instances covering read-old, write-first
// and write-first with output register plus non-zero clear value.
module tb_dpram_bw;

    logic        clk = 1'b0;
    logic        rstn_i, ena_i, clr_i;
    logic [4:0]  adr_i, xadr_i;
    logic [31:0] dat_i, xdat_i;
    logic [3:0]  wre_i, xwre_i;

    logic [31:0] a_dat, a_xdat, b_dat, b_xdat, c_dat, c_xdat;
    logic        a_vld, a_xvld, b_vld, b_xvld, c_vld, c_xvld;
    logic        a_bsy, b_bsy, c_bsy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dpram_bw #(.AW(5), .NL(4), .LW(8), .WMODE(0), .OREG(0), .INITV(8'h00)) u_a (
        .clk_i(clk), .rstn_i(rstn_i), .ena_i(ena_i), .clr_i(clr_i), .bsy_o(a_bsy),
        .adr_i(adr_i), .dat_i(dat_i), .wre_i(wre_i), .dat_o(a_dat), .vld_o(a_vld),
        .xadr_i(xadr_i), .xdat_i(xdat_i), .xwre_i(xwre_i), .xdat_o(a_xdat), .xvld_o(a_xvld));

    dpram_bw #(.AW(5), .NL(4), .LW(8), .WMODE(1), .OREG(0), .INITV(8'h00)) u_b (
        .clk_i(clk), .rstn_i(rstn_i), .ena_i(ena_i), .clr_i(clr_i), .bsy_o(b_bsy),
        .adr_i(adr_i), .dat_i(dat_i), .wre_i(wre_i), .dat_o(b_dat), .vld_o(b_vld),
        .xadr_i(xadr_i), .xdat_i(xdat_i), .xwre_i(xwre_i), .xdat_o(b_xdat), .xvld_o(b_xvld));

    dpram_bw #(.AW(5), .NL(4), .LW(8), .WMODE(1), .OREG(1), .INITV(8'h5A)) u_c (
        .clk_i(clk), .rstn_i(rstn_i), .ena_i(ena_i), .clr_i(clr_i), .bsy_o(c_bsy),
        .adr_i(adr_i), .dat_i(dat_i), .wre_i(wre_i), .dat_o(c_dat), .vld_o(c_vld),
        .xadr_i(xadr_i), .xdat_i(xdat_i), .xwre_i(xwre_i), .xdat_o(c_xdat), .xvld_o(c_xvld));

    typedef struct {
        logic        ena;
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  wre;
        logic [4:0]  xadr;
        logic [31:0] xdat;
        logic [3:0]  xwre;
        logic        v;
        logic [31:0] ea, exa, eb, exb;
    } vec_t;

    typedef struct {
        logic        ena;
        logic [4:0]  adr, xadr;
        logic        v;
        logic        cd;
        logic [31:0] ed, ex;
    } cvec_t;

    vec_t  vt[13];
    cvec_t cs[8];

    function automatic vec_t mk(input logic ena, input logic [4:0] adr, input logic [31:0] dat,
                                input logic [3:0] wre, input logic [4:0] xadr, input logic [31:0] xdat,
                                input logic [3:0] xwre, input logic v, input logic [31:0] ea,
                                input logic [31:0] exa, input logic [31:0] eb, input logic [31:0] exb);
        vec_t r;
        r.ena = ena; r.adr = adr; r.dat = dat; r.wre = wre;
        r.xadr = xadr; r.xdat = xdat; r.xwre = xwre;
        r.v = v; r.ea = ea; r.exa = exa; r.eb = eb; r.exb = exb;
        return r;
    endfunction

    function automatic cvec_t mkc(input logic ena, input logic [4:0] adr, input logic [4:0] xadr,
                                  input logic v, input logic cd, input logic [31:0] ed, input logic [31:0] ex);
        cvec_t r;
        r.ena = ena; r.adr = adr; r.xadr = xadr; r.v = v; r.cd = cd; r.ed = ed; r.ex = ex;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drv(input logic ena, input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] wre,
                       input logic [4:0] xadr, input logic [31:0] xdat, input logic [3:0] xwre);
        ena_i = ena; adr_i = adr; dat_i = dat; wre_i = wre;
        xadr_i = xadr; xdat_i = xdat; xwre_i = xwre;
    endtask

    task automatic count_sweep(input string nm, input logic drive_writes);
        int n   = 0;
        int bad = 0;
        if (drive_writes) drv(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF, 5'd6, 32'hFFFF_FFFF, 4'hF);
        while (a_bsy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (a_vld || a_xvld || c_vld) bad++;
            if (n == 10) clr_i = 1'b1;
            if (n == 11) clr_i = 1'b0;
        end
        drv(1'b0, '0, '0, '0, '0, '0, '0);
        chk({nm, " bsy cycles"}, 32'(n), 32'd32);
        chk({nm, " no strobe in sweep"}, 32'(bad), 32'd0);
        chk({nm, " c bsy done"}, 32'(c_bsy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = mk(1'b1, 5'd3,  32'h1122_3344, 4'hF, 5'd4,  32'h0,         4'h0, 1'b1,
                    32'h0,         32'h0,         32'h1122_3344, 32'h0);
        vt[1]  = mk(1'b1, 5'd3,  32'hAABB_CCDD, 4'h5, 5'd3,  32'h0,         4'h0, 1'b1,
                    32'h1122_3344, 32'h1122_3344, 32'h11BB_33DD, 32'h11BB_33DD);
        vt[2]  = mk(1'b1, 5'd3,  32'h0,         4'h0, 5'd3,  32'h0,         4'h0, 1'b1,
                    32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD);
        vt[3]  = mk(1'b1, 5'd7,  32'h0000_00FF, 4'h3, 5'd7,  32'h0000_FF00, 4'h6, 1'b1,
                    32'h0,         32'h0,         32'h0000_00FF, 32'h0000_00FF);
        vt[4]  = mk(1'b1, 5'd8,  32'hA1A2_A3A4, 4'h3, 5'd8,  32'hB1B2_B3B4, 4'h6, 1'b1,
                    32'h0,         32'h0,         32'h00B2_A3A4, 32'h00B2_A3A4);
        vt[5]  = mk(1'b1, 5'd7,  32'h0,         4'h0, 5'd8,  32'h0,         4'h0, 1'b1,
                    32'h0000_00FF, 32'h00B2_A3A4, 32'h0000_00FF, 32'h00B2_A3A4);
        vt[6]  = mk(1'b1, 5'd9,  32'h1,         4'hF, 5'd10, 32'h0,         4'h0, 1'b1,
                    32'h0,         32'h0,         32'h1,         32'h0);
        vt[7]  = mk(1'b1, 5'd9,  32'h2,         4'hF, 5'd9,  32'h0,         4'h0, 1'b1,
                    32'h1,         32'h1,         32'h2,         32'h2);
        vt[8]  = mk(1'b0, 5'd9,  32'hDEAD_BEEF, 4'hF, 5'd0,  32'h1234_5678, 4'hF, 1'b0,
                    32'h1,         32'h1,         32'h2,         32'h2);
        vt[9]  = mk(1'b1, 5'd9,  32'h0,         4'h0, 5'd0,  32'h0,         4'h0, 1'b1,
                    32'h2,         32'h0,         32'h2,         32'h0);
        vt[10] = mk(1'b1, 5'd12, 32'h0,         4'h0, 5'd12, 32'hCAFE_F00D, 4'hF, 1'b1,
                    32'h0,         32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D);
        vt[11] = mk(1'b1, 5'd13, 32'h1313_1313, 4'hF, 5'd12, 32'h0,         4'h0, 1'b1,
                    32'h0,         32'hCAFE_F00D, 32'h1313_1313, 32'hCAFE_F00D);
        vt[12] = mk(1'b1, 5'd3,  32'h0,         4'h0, 5'd13, 32'h0,         4'h0, 1'b1,
                    32'h11BB_33DD, 32'h1313_1313, 32'h11BB_33DD, 32'h1313_1313);

        // Output-register instance: data lands two edges after each enabled access.
        cs[0] = mkc(1'b1, 5'd9,  5'd12, 1'b0, 1'b0, 32'h0,         32'h0);
        cs[1] = mkc(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 32'h2,         32'hCAFE_F00D);
        cs[2] = mkc(1'b1, 5'd13, 5'd3,  1'b0, 1'b1, 32'h2,         32'hCAFE_F00D);
        cs[3] = mkc(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 32'h1313_1313, 32'h11BB_33DD);
        cs[4] = mkc(1'b1, 5'd7,  5'd8,  1'b0, 1'b1, 32'h1313_1313, 32'h11BB_33DD);
        cs[5] = mkc(1'b1, 5'd8,  5'd7,  1'b1, 1'b1, 32'h5A00_00FF, 32'h5AB2_A3A4);
        cs[6] = mkc(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 32'h5AB2_A3A4, 32'h5A00_00FF);
        cs[7] = mkc(1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 32'h5AB2_A3A4, 32'h5A00_00FF);

        rstn_i = 1'b0;
        clr_i  = 1'b0;
        drv(1'b0, '0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst a.dat", a_dat, 32'h0);
        chk("rst a.vld", 32'(a_vld), 32'd0);
        chk("rst a.bsy", 32'(a_bsy), 32'd1);
        chk("rst c.dat", c_dat, 32'h0);
        chk("rst c.bsy", 32'(c_bsy), 32'd1);

        rstn_i = 1'b1;
        count_sweep("init", 1'b0);

        for (int i = 0; i < 32; i++) begin
            drv(1'b1, 5'(i), '0, '0, 5'(31 - i), '0, '0);
            @(negedge clk);
            chk($sformatf("zero a.dat[%0d]", i), a_dat, 32'h0);
            chk($sformatf("zero a.xdat[%0d]", 31 - i), a_xdat, 32'h0);
            chk($sformatf("zero a.vld[%0d]", i), 32'(a_vld & a_xvld), 32'd1);
        end
        drv(1'b0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        chk("idle a.vld", 32'(a_vld | a_xvld), 32'd0);

        for (int i = 0; i < 13; i++) begin
            drv(vt[i].ena, vt[i].adr, vt[i].dat, vt[i].wre, vt[i].xadr, vt[i].xdat, vt[i].xwre);
            @(negedge clk);
            chk($sformatf("v%0d a.dat", i),  a_dat,  vt[i].ea);
            chk($sformatf("v%0d a.xdat", i), a_xdat, vt[i].exa);
            chk($sformatf("v%0d b.dat", i),  b_dat,  vt[i].eb);
            chk($sformatf("v%0d b.xdat", i), b_xdat, vt[i].exb);
            chk($sformatf("v%0d vld", i), {28'b0, a_vld, a_xvld, b_vld, b_xvld}, {28'b0, {4{vt[i].v}}});
        end

        drv(1'b0, '0, '0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drv(cs[i].ena, cs[i].adr, '0, '0, cs[i].xadr, '0, '0);
            @(negedge clk);
            chk($sformatf("oreg%0d c.vld", i), {30'b0, c_vld, c_xvld}, {30'b0, {2{cs[i].v}}});
            if (cs[i].cd) begin
                chk($sformatf("oreg%0d c.dat", i),  c_dat,  cs[i].ed);
                chk($sformatf("oreg%0d c.xdat", i), c_xdat, cs[i].ex);
            end
        end

        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr bsy rise", 32'(a_bsy & c_bsy), 32'd1);
        count_sweep("clr", 1'b1);

        for (int i = 0; i < 32; i++) begin
            drv(1'b1, 5'(i), '0, '0, 5'(31 - i), '0, '0);
            @(negedge clk);
            chk($sformatf("clr a.dat[%0d]", i), a_dat, 32'h0);
            chk($sformatf("clr a.xdat[%0d]", 31 - i), a_xdat, 32'h0);
            chk($sformatf("clr c.vld[%0d]", i), 32'(c_vld), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) begin
                chk($sformatf("clr c.dat[%0d]", i - 1), c_dat, 32'h5A5A_5A5A);
                chk($sformatf("clr c.xdat[%0d]", 32 - i), c_xdat, 32'h5A5A_5A5A);
            end
        end
        drv(1'b0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        chk("clr c.dat[31]", c_dat, 32'h5A5A_5A5A);
        chk("clr c.vld tail", 32'(c_vld), 32'd1);
        @(negedge clk);
        chk("clr c.vld off", 32'(c_vld), 32'd0);
        chk("clr c.dat hold", c_dat, 32'h5A5A_5A5A);

        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("async rst c.dat", c_dat, 32'h0);
        chk("async rst c.xdat", c_xdat, 32'h0);
        chk("async rst bsy", 32'(a_bsy & c_bsy), 32'd1);
        @(negedge clk);
        rstn_i = 1'b1;
        count_sweep("restart", 1'b0);

        drv(1'b1, 5'd3, '0, '0, 5'd9, '0, '0);
        @(negedge clk);
        chk("post a.dat", a_dat, 32'h0);
        chk("post a.vld", 32'(a_vld), 32'd1);
        drv(1'b0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
